stack_xfer_sequencer: RTL
=========================

Name: stack_xfer_sequencer

Overview:
- Multi-cycle controller for Thumb-style PUSH/POP (register-list) instructions.
- Walks an 8-bit low-register list plus an optional LR bit, one register at a time.
- Drives the register file's read select and write port, the SP write port, and a single-beat data-memory request/ack interface.
- Sits between decode and the register file; stalls the front-end while a list transfer is in flight.

Parameters:
- LIST_W, 8, number of low registers in the list (r0..r(LIST_W-1)); must be at most 8.
- WORD_BYTES, 4, byte stride per transferred register.
- SEL_SP, 4'hD, register-file select code for SP.
- SEL_LR, 4'hE, register-file select code for LR.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start_i  in  1  request to start a list transfer; sampled in IDLE only.
- pop_i  in  1  1 = POP (memory to registers), 0 = PUSH; latched with start_i.
- reg_list_i  in  LIST_W  register list, bit k = rk; latched with start_i.
- lr_i  in  1  include LR (PUSH stores LR, POP loads LR); latched with start_i.
- sp_i  in  32  current SP value, valid when start_i is high.
- rd_data_i  in  32  register-file data_out0; valid the cycle after rd0_select_o is presented.
- rd0_select_o  out  4  register-file read select.
- wr_select_o  out  4  register-file write select.
- wr_data_o  out  32  register-file data_in.
- write_en_o  out  1  register-file write enable.
- sp_write_en_o  out  1  register-file SP write enable.
- sp_out_o  out  32  register-file sp_in.
- mem_req_o  out  1  memory request; held until mem_ack_i.
- mem_we_o  out  1  1 = store (PUSH), 0 = load (POP).
- mem_addr_o  out  32  byte address.
- mem_wdata_o  out  32  store data.
- mem_ack_i  in  1  one-cycle acknowledge; mem_rdata_i is valid in the same cycle.
- mem_rdata_i  in  32  load data.
- busy_o  out  1  high in every state except IDLE.
- stall_o  out  1  equals busy_o; front-end (fetch/decode) stall.
- done_o  out  1  one-cycle pulse at completion.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; pending list 0.
  - Reset asserted mid-transfer aborts immediately: mem_req_o drops, no SP update, no done_o.
- Integration rule: register-file stall_i must be held low while busy_o is high, because the sequencer needs live reads.
- Transfer count and addressing:
  - n = popcount(reg_list_i) + lr_i, range 0..9.
  - All address and SP arithmetic is modulo 2^32; no alignment check.
- Start (IDLE, posedge with start_i=1):
  - Latch list, lr, and pop.
  - base = PUSH ? sp_i - WORD_BYTES*n : sp_i.
  - addr = base.
  - Next state: n==0 -> DONE; PUSH -> RD; POP -> MEM.
  - start_i outside IDLE is ignored.
- Order: ascending, r0 first, LR last (LR gets the highest address).
- PUSH path:
  - RD (1 cycle): rd0_select_o = lowest pending register (SEL_LR if only LR remains).
  - CAP (1 cycle): latch rd_data_i into mem_wdata_o.
  - MEM: mem_req_o=1, mem_we_o=1; mem_addr_o and mem_wdata_o stable until ack.
  - On ack: clear that pending bit, addr += WORD_BYTES; next is RD if bits remain, else SPUPD.
  - Minimum 3 cycles per register.
- POP path:
  - MEM: mem_req_o=1, mem_we_o=0; wait for ack.
  - On ack: register mem_rdata_i.
  - WB (1 cycle): write_en_o=1, wr_select_o = current register, wr_data_o = registered data. Then clear the bit and addr += WORD_BYTES; next is MEM if bits remain, else SPUPD.
  - Minimum 2 cycles per register.
- SPUPD (1 cycle): sp_write_en_o=1, sp_out_o = PUSH ? base : base + WORD_BYTES*n.
- DONE (1 cycle): done_o=1, then IDLE. An empty list reaches DONE directly, with no memory access and no SP write.
- write_en_o and sp_write_en_o are never high in the same cycle.
- mem_req_o is never high in RD, CAP, WB, SPUPD, or DONE.

Decomposition:
- Package stack_xfer_pkg:
  - State enum: IDLE, RD, CAP, MEM, WB, SPUPD, DONE.
  - SEL_SP/SEL_LR defaults and WORD_BYTES.
  - Popcount function.
- One sub-module, stack_xfer_pick: combinational lowest-set-bit finder over {lr, list}. Outputs a 4-bit select and a one-hot clear mask.

Test Plan:
- PUSH {r0,r1,LR}, sp_i=0x2000, regs r0=0, r1=0x11111111, LR=0xEEEEFFFF, ack the cycle after req -> stores 0x0@0x1FF4, 0x11111111@0x1FF8, 0xEEEEFFFF@0x1FFC; then sp_out_o=0x1FF4 with sp_write_en_o for 1 cycle; done_o 1 cycle.
- POP {r2,r4}, sp_i=0x1FF4, rdata 0xA5A5A5A5 then 0x5A5A5A5A -> loads @0x1FF4 and @0x1FF8; r2=0xA5A5A5A5, r4=0x5A5A5A5A via WB cycles; sp_out_o=0x1FFC.
- Empty list (list=0, lr=0) -> done_o one cycle after start; no mem_req_o, no write_en_o, no sp_write_en_o.
- Memory wait: ack delayed 3 cycles on each beat -> mem_req_o, mem_addr_o, and mem_wdata_o held constant; busy_o and stall_o high throughout.
- Reset low during the second MEM of PUSH {r0..r7} -> all outputs 0 asynchronously, no SP write; a fresh start after reset completes normally.
- start_i pulsed while busy, and sp_i=0x4 with PUSH of 3 regs -> second start ignored; base wraps to 0xFFFFFFF8 and addresses run 0xFFFFFFF8, 0xFFFFFFFC, 0x0.

Source files
------------

// File: rtl/stack_xfer_pkg.sv
// -----------------------------------------------------------------------------
// stack_xfer_pkg
// Shared definitions for the PUSH/POP register-list sequencer:
//   - xfer_state_e : sequencer FSM states
//   - *_DEF        : default parameter values (list width, byte stride,
//                    register-file select codes for SP and LR)
//   - popcount8    : number of set bits in an 8-bit register list
// -----------------------------------------------------------------------------
package stack_xfer_pkg;

  localparam int unsigned LIST_W_DEF     = 8;
  localparam int unsigned WORD_BYTES_DEF = 4;
  localparam logic [3:0]  SEL_SP_DEF     = 4'hD;
  localparam logic [3:0]  SEL_LR_DEF     = 4'hE;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    MEM,
    WB,
    SPUPD,
    DONE
  } xfer_state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/stack_xfer_pick.sv
// -----------------------------------------------------------------------------
// stack_xfer_pick
// Combinational lowest-set-bit finder over the pending transfer vector
// {lr, list}. Low registers win over LR, so LR is always transferred last.
// Ports:
//   pending_i  in  LIST_W+1  pending bits, bit LIST_W = LR, bit k = rk
//   sel_o      out 4         register-file select of the lowest pending bit
//   clear_o    out LIST_W+1  one-hot mask of that bit (all zero if none)
// -----------------------------------------------------------------------------
module stack_xfer_pick
  import stack_xfer_pkg::*;
#(
  parameter int unsigned LIST_W = LIST_W_DEF,
  parameter logic [3:0]  SEL_LR = SEL_LR_DEF
) (
  input  logic [LIST_W:0] pending_i,
  output logic [3:0]      sel_o,
  output logic [LIST_W:0] clear_o
);

  logic found;

  always_comb begin
    sel_o   = '0;
    clear_o = '0;
    found   = 1'b0;
    for (int k = 0; k < int'(LIST_W); k++) begin
      if (pending_i[k] && !found) begin
        sel_o      = 4'(k);
        clear_o[k] = 1'b1;
        found      = 1'b1;
      end
    end
    if (!found && pending_i[LIST_W]) begin
      sel_o           = SEL_LR;
      clear_o[LIST_W] = 1'b1;
    end
  end

endmodule

// File: rtl/stack_xfer_sequencer.sv
// -----------------------------------------------------------------------------
// stack_xfer_sequencer
// Multi-cycle controller for Thumb-style PUSH/POP register-list instructions.
// Walks the low-register list (ascending) and then LR, moving one register per
// single-beat memory transaction, and finally writes back SP.
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   start_i/pop_i/reg_list_i/lr_i/sp_i   transfer request (sampled in IDLE)
//   rd_data_i, rd0_select_o              register-file read port
//   wr_select_o/wr_data_o/write_en_o     register-file write port
//   sp_write_en_o/sp_out_o               register-file SP write port
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_ack_i/mem_rdata_i
//                                        single-beat data-memory interface
//   busy_o/stall_o                       high whenever not IDLE
//   done_o                               one-cycle completion pulse
// The register file must not be stalled while busy_o is high: PUSH relies on
// a live read the cycle after rd0_select_o is presented.
// -----------------------------------------------------------------------------
module stack_xfer_sequencer
  import stack_xfer_pkg::*;
#(
  parameter int unsigned LIST_W     = LIST_W_DEF,
  parameter int unsigned WORD_BYTES = WORD_BYTES_DEF,
  parameter logic [3:0]  SEL_SP     = SEL_SP_DEF,
  parameter logic [3:0]  SEL_LR     = SEL_LR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              pop_i,
  input  logic [LIST_W-1:0] reg_list_i,
  input  logic              lr_i,
  input  logic [31:0]       sp_i,
  input  logic [31:0]       rd_data_i,
  output logic [3:0]        rd0_select_o,
  output logic [3:0]        wr_select_o,
  output logic [31:0]       wr_data_o,
  output logic              write_en_o,
  output logic              sp_write_en_o,
  output logic [31:0]       sp_out_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              busy_o,
  output logic              stall_o,
  output logic              done_o
);

  localparam logic [31:0] STRIDE = 32'(WORD_BYTES);

  xfer_state_e     state_q, state_d;
  logic [LIST_W:0] pend_q, pend_d;
  logic            pop_q, pop_d;
  logic [3:0]      n_q, n_d;
  logic [31:0]     base_q, base_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [7:0]      listExt;
  logic [3:0]      startN;
  logic [31:0]     startSpan;
  logic [31:0]     spanQ;
  logic [3:0]      pickSel;
  logic [LIST_W:0] pickClear;
  logic [LIST_W:0] pendAfter;

  stack_xfer_pick #(
    .LIST_W (LIST_W),
    .SEL_LR (SEL_LR)
  ) u_pick (
    .pending_i (pend_q),
    .sel_o     (pickSel),
    .clear_o   (pickClear)
  );

  always_comb begin
    listExt               = '0;
    listExt[LIST_W-1:0]   = reg_list_i;
  end

  assign startN    = popcount8(listExt) + {3'b000, lr_i};
  assign startSpan = STRIDE * {28'd0, startN};
  assign spanQ     = STRIDE * {28'd0, n_q};
  assign pendAfter = pend_q & ~pickClear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      pop_q   <= 1'b0;
      n_q     <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      pop_q   <= pop_d;
      n_q     <= n_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs are decoded from the state so that every output returns to zero
  // as soon as reset forces the state register back to IDLE.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    pop_d   = pop_q;
    n_d     = n_q;
    base_d  = base_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    rd0_select_o  = '0;
    wr_select_o   = '0;
    wr_data_o     = '0;
    write_en_o    = 1'b0;
    sp_write_en_o = 1'b0;
    sp_out_o      = '0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    busy_o        = (state_q != IDLE);
    stall_o       = (state_q != IDLE);
    done_o        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          pend_d = {lr_i, reg_list_i};
          pop_d  = pop_i;
          n_d    = startN;
          // PUSH pre-decrements SP by the whole block so the lowest register
          // lands at the lowest address; POP starts at the current SP.
          base_d = pop_i ? sp_i : (sp_i - startSpan);
          addr_d = base_d;
          if (startN == 4'd0) begin
            state_d = DONE;
          end else if (pop_i) begin
            state_d = MEM;
          end else begin
            state_d = RD;
          end
        end
      end

      RD: begin
        rd0_select_o = pickSel;
        state_d      = CAP;
      end

      CAP: begin
        wdata_d = rd_data_i;
        state_d = MEM;
      end

      MEM: begin
        mem_req_o   = 1'b1;
        mem_we_o    = !pop_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = pop_q ? 32'd0 : wdata_q;
        if (mem_ack_i) begin
          if (pop_q) begin
            rdata_d = mem_rdata_i;
            state_d = WB;
          end else begin
            pend_d  = pendAfter;
            addr_d  = addr_q + STRIDE;
            state_d = (pendAfter != '0) ? RD : SPUPD;
          end
        end
      end

      WB: begin
        write_en_o  = 1'b1;
        wr_select_o = pickSel;
        wr_data_o   = rdata_q;
        pend_d      = pendAfter;
        addr_d      = addr_q + STRIDE;
        state_d     = (pendAfter != '0) ? MEM : SPUPD;
      end

      SPUPD: begin
        // The write select also points at SP here for register files that
        // share one select between the general and SP write paths.
        sp_write_en_o = 1'b1;
        wr_select_o   = SEL_SP;
        sp_out_o      = pop_q ? (base_q + spanQ) : base_q;
        state_d       = DONE;
      end

      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
